// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NUM_REQ requesters.
// A requester wins arbitration in IDLE, its operands are registered onto the
// ALU inputs, the ALU result is captured one cycle later, and the result is
// returned to the winner over a valid/ready handshake.
//
// Build option: define ALU_ARBITER_FIXED_PRIO_EN for fixed-priority
// arbitration (lowest requesting index wins, no rotating pointer). The default
// build (macro undefined) uses round-robin arbitration.

module alu_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [4*NUM_REQ-1:0]  req_op,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [3:0]            alu_op,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    input  logic [31:0]           alu_out,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic           any_valid;
    logic [IDW-1:0] winner;
    logic           accept;
    logic [3:0]     sel_op;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic           rsp_go;

`ifdef ALU_ARBITER_FIXED_PRIO_EN

    // Fixed priority: scan from the top down so the lowest requesting index is the last (and final) winner.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_valid = 1'b1;
                winner    = IDW'(i);
            end
        end
    end

`else

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW:0]   scan_sum;
    logic [IDW-1:0] scan_idx;

    // Round-robin: visit ptr, ptr+1, ... modulo NUM_REQ and take the first requester found.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr} + (IDW+1)'(k);
            if (scan_sum >= (IDW+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (IDW+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!any_valid && req_valid[scan_idx]) begin
                any_valid = 1'b1;
                winner    = scan_idx;
            end
        end
    end

    // The index after the winner gets top priority next time, wrapping at NUM_REQ-1.
    always_comb begin
        if (winner == IDW'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = winner + IDW'(1);
        end
    end

`endif

    // Reset wins over every handshake, so no request is acknowledged while RST is high.
    assign accept = (state == IDLE) && any_valid && !RST;

    // Route the winner's opcode and operands toward the operand registers.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
                sel_op = req_op[i*4 +: 4];
                sel_a  = req_a[i*32 +: 32];
                sel_b  = req_b[i*32 +: 32];
            end
        end
    end

    // Acknowledge only the winner, and only in IDLE.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (winner == IDW'(i));
        end
    end

    // Present the result only to the current owner; ready from any other index is ignored.
    always_comb begin
        rsp_valid = '0;
        rsp_go    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                rsp_valid[i] = (state == RESP) && !RST;
                rsp_go       = rsp_ready[i];
            end
        end
    end

    assign busy = (state != IDLE);

    // Arbiter FSM; the ALU inputs, grant id and result are all registered here so nothing on req_* reaches alu_* combinationally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            grant_id <= '0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            rsp_data <= '0;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
            ptr      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        alu_op   <= sel_op;
                        alu_a    <= sel_a;
                        alu_b    <= sel_b;
                        grant_id <= winner;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
                        ptr      <= ptr_next;
`endif
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= alu_out;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_go) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level model (arbitration pick function, ALU function, fixed
// accept/response timing). The bench also plays the role of the ALU.
// Honours ALU_ARBITER_FIXED_PRIO_EN when the design is built with it.

module tb_alu_arbiter;

    localparam int N = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [4*N-1:0]  req_op;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [31:0]     rsp_data;
    logic [3:0]      alu_op;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic [31:0]     alu_out;
    logic [1:0]      grant_id;
    logic            busy;

    logic [3:0]  op_q [N];
    logic [31:0] a_q  [N];
    logic [31:0] b_q  [N];

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // 100 MHz style clock
    always #5 CLK = ~CLK;

    // Reference ALU: 2 is addition, the rest are a handful of ordinary ops.
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h3:    return a - b;
            4'h4:    return a ^ b;
            4'h5:    return a << b[4:0];
            4'h6:    return a >> b[4:0];
            4'h7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return ~(a ^ b);
        endcase
    endfunction

    // The bench is the ALU attached to the arbiter.
    always_comb alu_out = alu_ref(alu_op, alu_a, alu_b);

    // Per-requester operand storage flattened onto the request buses.
    always_comb begin
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        for (int i = 0; i < N; i++) begin
            req_op[i*4 +: 4]   = op_q[i];
            req_a[i*32 +: 32]  = a_q[i];
            req_b[i*32 +: 32]  = b_q[i];
        end
    end

    // Which requester should win, given the request set and the model pointer.
    function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef ALU_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
`endif
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic new_operands(input int i);
        op_q[i] = 4'($urandom_range(0, 8));
        a_q[i]  = $urandom;
        b_q[i]  = $urandom;
    endtask

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_busy"},      32'(busy),      32'd0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_data"},  rsp_data,       32'd0);
        checkOutput({tag, "_grant_id"},  32'(grant_id),  32'd0);
        checkOutput({tag, "_alu_op"},    32'(alu_op),    32'd0);
        checkOutput({tag, "_alu_a"},     alu_a,          32'd0);
        checkOutput({tag, "_alu_b"},     alu_b,          32'd0);
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        next_cycle();
        next_cycle();
        RST   = 1'b0;
        ptr_m = 0;
        @(negedge CLK);
        check_reset_state("reset");
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        next_cycle();
    endtask

    // One full transaction: offer mask in IDLE, expect the model's winner to be
    // accepted, then EXEC, then stall+1 RESP cycles with the release in the last.
    // extra requesters raise valid while busy; keep_extra leaves them up after release.
    task automatic applyStimulus(input logic [N-1:0] mask, input logic [N-1:0] extra,
                                 input int stall, input bit keep_extra, output int w);
        logic [N-1:0] bit_w;
        logic [3:0]   op_s;
        logic [31:0]  a_s, b_s, exp;
        req_valid = mask;
        rsp_ready = '0;
        w     = pick(mask, ptr_m);
        bit_w = N'(1) << w;
        op_s  = op_q[w];
        a_s   = a_q[w];
        b_s   = b_q[w];
        exp   = alu_ref(op_s, a_s, b_s);
        @(negedge CLK);
        checkOutput("accept_req_ready", 32'(req_ready), 32'(bit_w));
        checkOutput("accept_busy",      32'(busy),      32'd0);
        checkOutput("accept_rsp_valid", 32'(rsp_valid), 32'd0);
        next_cycle();
`ifndef ALU_ARBITER_FIXED_PRIO_EN
        ptr_m = (w + 1) % N;
`endif
        new_operands(w);
        req_valid = (mask & ~bit_w) | extra;
        @(negedge CLK);
        checkOutput("exec_busy",      32'(busy),      32'd1);
        checkOutput("exec_req_ready", 32'(req_ready), 32'd0);
        checkOutput("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("exec_grant_id",  32'(grant_id),  32'(w));
        checkOutput("exec_alu_op",    32'(alu_op),    32'(op_s));
        checkOutput("exec_alu_a",     alu_a,          a_s);
        checkOutput("exec_alu_b",     alu_b,          b_s);
        for (int r = 0; r <= stall; r++) begin
            next_cycle();
            if (r == stall) begin
                rsp_ready = bit_w | (N'($urandom) & ~bit_w);
                if (!keep_extra) req_valid = mask & ~bit_w;
            end else begin
                rsp_ready = N'($urandom) & ~bit_w;
            end
            @(negedge CLK);
            checkOutput("resp_rsp_valid", 32'(rsp_valid), 32'(bit_w));
            checkOutput("resp_rsp_data",  rsp_data,       exp);
            checkOutput("resp_req_ready", 32'(req_ready), 32'd0);
            checkOutput("resp_busy",      32'(busy),      32'd1);
        end
        next_cycle();
        rsp_ready = '0;
    endtask

    // Start an op for requester 1, then hit reset in EXEC (phase 1) or RESP (phase 2).
    task automatic reset_mid_op(input int phase);
        int w;
        req_valid = 4'b0010;
        rsp_ready = '0;
        w = pick(req_valid, ptr_m);
        @(negedge CLK);
        checkOutput("rmid_req_ready", 32'(req_ready), 32'(N'(1) << w));
        next_cycle();
        req_valid = '0;
        if (phase == 2) next_cycle();
        RST       = 1'b1;
        rsp_ready = '1;
        next_cycle();
        RST   = 1'b0;
        ptr_m = 0;
        @(negedge CLK);
        check_reset_state(phase == 1 ? "rst_exec" : "rst_resp");
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge CLK);
            checkOutput("rst_drop_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("rst_drop_busy",      32'(busy),      32'd0);
        end
        rsp_ready = '0;
        next_cycle();
    endtask

    initial begin
        int w;
        logic [N-1:0] m, x;
        RST       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) new_operands(i);

        // Reset values
        do_reset();

        // Single request: 5 + 7 from requester 1
        op_q[1] = 4'h2;
        a_q[1]  = 32'd5;
        b_q[1]  = 32'd7;
        checkOutput("single_model_sum", alu_ref(op_q[1], a_q[1], b_q[1]) , 32'd12);
        applyStimulus(4'b0010, 4'b0000, 0, 1'b0, w);

        // All four valid from reset, then only 0 and 3
        do_reset();
        for (int t = 0; t < 4; t++) applyStimulus(4'b1111, 4'b0000, 0, 1'b0, w);
        for (int t = 0; t < 4; t++) applyStimulus(4'b1001, 4'b0000, 0, 1'b0, w);

        // Wrap-around: serve 2 so the pointer sits at 3, then 0 and 3 request
        do_reset();
        applyStimulus(4'b0100, 4'b0000, 0, 1'b0, w);
        applyStimulus(4'b1001, 4'b0000, 0, 1'b0, w);
        applyStimulus(4'b1001, 4'b0000, 0, 1'b0, w);

        // Back-pressure: requester 0 stalled 10 cycles while requester 2 waits
        applyStimulus(4'b0001, 4'b0100, 10, 1'b1, w);
        applyStimulus(4'b0100, 4'b0000, 0, 1'b0, w);

        // Abandoned request from requester 1 while busy
        applyStimulus(4'b0001, 4'b0010, 2, 1'b0, w);
        @(negedge CLK);
        checkOutput("abandon_req_ready", 32'(req_ready), 32'd0);
        checkOutput("abandon_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abandon_busy",      32'(busy),      32'd0);
        next_cycle();
        applyStimulus(4'b1111, 4'b0000, 0, 1'b0, w);

        // Reset during EXEC and during RESP
        reset_mid_op(1);
        reset_mid_op(2);
        applyStimulus(4'b1110, 4'b0000, 1, 1'b0, w);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            m = N'($urandom_range(1, 15));
            x = N'($urandom);
            applyStimulus(m, x, $urandom_range(0, 3), 1'($urandom), w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU datapath (op[3:0], A[31:0], B[31:0] -> out[31:0]) among NUM_REQ requesters. It arbitrates requests, registers the winning operands into the ALU, captures the result, and returns it to the winner over a valid/ready handshake. It sits between the requesting units and the `alu` instance and is the only driver of the ALU inputs.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NUM_REQ), width of the grant id (derived; do not override).

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester request accepted; at most one bit high.
- req_op  input  4*NUM_REQ  opcode; requester i uses bits [4i+3:4i].
- req_a  input  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i].
- req_b  input  32*NUM_REQ  operand B; same slicing as req_a.
- rsp_valid  output  NUM_REQ  per-requester result valid; one-hot or zero.
- rsp_ready  input  NUM_REQ  per-requester result consumed.
- rsp_data  output  32  result shared by all requesters; qualified by rsp_valid.
- alu_op  output  4  to ALU op.
- alu_a  output  32  to ALU A.
- alu_b  output  32  to ALU B.
- alu_out  input  32  from ALU out (combinational).
- grant_id  output  IDW  index of the requester currently owning the ALU.
- busy  output  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, the winner w is selected combinationally and req_ready[w]=1 in the same cycle.
  - req_op/a/b slice w is registered into the operand regs, grant_id<=w, and the next state is EXEC.
  - If no req_valid is high, the block stays in IDLE.
- EXEC: alu_out is captured into the result register; next state is RESP. Exactly one cycle.
- RESP:
  - rsp_valid[grant_id]=1 and rsp_data=result register.
  - When rsp_ready[grant_id]=1, the next state is IDLE.
  - Otherwise the block holds RESP with rsp_data stable.
- alu_op/alu_a/alu_b always drive the operand regs directly, with no combinational path from req_* to alu_*.
- Arbitration is round-robin:
  - Pointer ptr (IDW bits) is the highest-priority index.
  - The winner is the first i with req_valid[i], scanning ptr, ptr+1, ... modulo NUM_REQ.
  - On acceptance, ptr<=(w+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- Requester rules:
  - A requester must hold req_valid and operands stable until req_ready.
  - A requester may deassert req_valid before req_ready without effect.
  - req_valid[i] may be high again while its own response is pending; it is not accepted until the FSM returns to IDLE.
- The result is 32 bits exactly as returned by the ALU; the arbiter does no width extension or modification.

## Timing
- Reset values: state=IDLE, ptr=0, grant_id=0, operand regs=0 (alu_op=0, alu_a=0, alu_b=0), result=0, req_ready=0, rsp_valid=0, rsp_data=0, busy=0.
- Latency: request accepted at cycle T (req_ready high) leads to rsp_valid high at T+2.
- Minimum per-op occupancy is 3 cycles (IDLE, EXEC, RESP with rsp_ready already high).
- Peak throughput is one op every 3 cycles.
- req_ready is asserted only in IDLE; never during EXEC or RESP.
- Simultaneous requests: only the winner sees req_ready. Losers keep req_valid and are served in later IDLE cycles in round-robin order.
- Back-pressure: rsp_ready low in RESP stalls indefinitely. No new request is accepted until rsp_ready is seen.
- rsp_ready on a non-granted index is ignored.
- RST high in any state:
  - Next cycle all registers take their reset values.
  - Any in-flight operation or pending response is dropped; no rsp_valid is issued for it.
  - RST takes precedence over every handshake in the same cycle.

## Configuration
- Macro ALU_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority. The winner is the lowest index i with req_valid[i]; ptr is neither implemented nor updated.
- Undefined (default): round-robin as described in Operation.
- All other behaviour and timing are identical in both builds.

## Test plan
- Single request: req_valid[1]=1, op=4'h2, A=5, B=7, bench ALU model computes A+B.
  - Required: req_ready[1] at T, rsp_valid[1] with rsp_data=12 at T+2, busy high at T+1..T+2.
- All four valid at once from reset, round-robin build.
  - Required: grant order 0,1,2,3.
  - Then with only 0 and 3 valid: order 0,3,0,3.
  - Fixed-prio build with all valid: requester 0 served every time.
- Wrap-around: ptr=3 (after serving 2) with req_valid=4'b1001.
  - Required: requester 3 wins, then ptr=0 and requester 0 wins next.
- Back-pressure: hold rsp_ready[0]=0 for 10 cycles in RESP with req_valid[2]=1.
  - Required: rsp_data stable for all 10 cycles; req_ready stays all-zero.
  - Release: requester 2 is accepted in the cycle after the RESP-to-IDLE transition.
- Reset mid-operation: assert RST during EXEC and, in a separate run, during RESP.
  - Required: rsp_valid=0 and all outputs at reset values on the next cycle; the dropped op is never responded to.
- Abandoned request: assert req_valid[1] while the FSM is busy, then deassert it before IDLE.
  - Required: no req_ready[1] and no response for requester 1; ptr unchanged.
